// File: rtl/csrfile_mtrap.sv
// Machine-mode CSR file with exception/interrupt trap entry, MRET return and a
// registered PC redirect back to fetch.
module csrfile_mtrap #(
    parameter int          XLEN        = 64,
    parameter int unsigned HARTID      = 0,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [11:0]     raddr,
    output logic [XLEN-1:0] rdata,
    output logic            rillegal,
    input  logic            wen,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            retire,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            int_ok,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            int_take,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [1:0]      PRIV_M = 2'b11;
    localparam logic [1:0]      PRIV_U = 2'b00;
    localparam logic [XLEN-1:0] ONE    = {{(XLEN-1){1'b0}}, 1'b1};

    logic            st_mie;
    logic            st_mpie;
    logic [1:0]      st_mpp;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;
    logic            irq_msip_q;
    logic            irq_mtip_q;
    logic            irq_meip_q;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [2:0]      pending;
    logic [3:0]      int_code;
    logic            int_enabled;
    logic            trap;
    logic            do_mret;
    logic            do_write;
    logic            hit;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] vec_offset;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mtvec_wval;

    always_comb begin
        mstatus_val         = '0;
        mstatus_val[3]      = st_mie;
        mstatus_val[7]      = st_mpie;
        mstatus_val[12:11]  = st_mpp;
        mip_val             = '0;
        mip_val[3]          = irq_msip_q;
        mip_val[7]          = irq_mtip_q;
        mip_val[11]         = irq_meip_q;
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (raddr)
            ADDR_MSTATUS:  rdata = mstatus_val;
            ADDR_MIE:      rdata = mie_q;
            ADDR_MTVEC:    rdata = mtvec_q;
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = mepc_q;
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MTVAL:    rdata = mtval_q;
            ADDR_MIP:      rdata = mip_val;
            ADDR_MCYCLE:   rdata = mcycle_q;
            ADDR_MINSTRET: rdata = minstret_q;
            ADDR_MHARTID:  rdata = XLEN'(HARTID);
            default:       hit   = 1'b0;
        endcase
        rillegal = !hit || (priv != PRIV_M);
    end

    // Event arbitration: exception beats interrupt beats MRET beats CSR write.
    always_comb begin
        pending     = {irq_meip_q & mie_q[11], irq_mtip_q & mie_q[7], irq_msip_q & mie_q[3]};
        int_enabled = (priv != PRIV_M) || st_mie;
        int_take    = int_ok && int_enabled && (pending != 3'b000) && !exc_valid;
        if (pending[2]) begin
            int_code = 4'd11;
        end else if (pending[0]) begin
            int_code = 4'd3;
        end else begin
            int_code = 4'd7;
        end
        trap     = exc_valid || int_take;
        do_mret  = mret && !trap;
        do_write = wen && !trap && !mret && (priv == PRIV_M);

        mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
        vec_offset = {{(XLEN-6){1'b0}}, int_code, 2'b00};
        if (exc_valid) begin
            trap_cause  = {{(XLEN-5){1'b0}}, exc_code};
            trap_target = mtvec_base;
        end else begin
            trap_cause  = {1'b1, {(XLEN-5){1'b0}}, int_code};
            trap_target = (VECTORED_EN && mtvec_q[0]) ? mtvec_base + vec_offset : mtvec_base;
        end

        mtvec_wval    = wdata;
        mtvec_wval[1] = 1'b0;
        if (!VECTORED_EN) begin
            mtvec_wval[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            priv    <= PRIV_M;
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            st_mpp  <= PRIV_U;
        end else if (trap) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            st_mpp  <= priv;
            priv    <= PRIV_M;
        end else if (do_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
            priv    <= st_mpp;
            st_mpp  <= PRIV_U;
        end else if (do_write && (waddr == ADDR_MSTATUS)) begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
            st_mpp  <= wdata[12:11];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtvec_q    <= '0;
            mie_q      <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap) begin
            mepc_q   <= exc_pc;
            mcause_q <= trap_cause;
            mtval_q  <= exc_valid ? exc_tval : '0;
        end else if (do_write) begin
            case (waddr)
                ADDR_MTVEC:    mtvec_q    <= mtvec_wval;
                ADDR_MIE:      mie_q      <= wdata;
                ADDR_MSCRATCH: mscratch_q <= wdata;
                ADDR_MEPC:     mepc_q     <= {wdata[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= wdata;
                ADDR_MTVAL:    mtval_q    <= wdata;
                default:       ;
            endcase
        end
    end

    // A software write to a counter takes the place of that cycle's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (do_write && (waddr == ADDR_MCYCLE)) begin
                mcycle_q <= wdata;
            end else begin
                mcycle_q <= mcycle_q + ONE;
            end
            if (do_write && (waddr == ADDR_MINSTRET)) begin
                minstret_q <= wdata;
            end else if (retire) begin
                minstret_q <= minstret_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_msip_q <= 1'b0;
            irq_mtip_q <= 1'b0;
            irq_meip_q <= 1'b0;
        end else begin
            irq_msip_q <= irq_msip;
            irq_mtip_q <= irq_mtip;
            irq_meip_q <= irq_meip;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap || do_mret;
            if (trap) begin
                redirect_pc <= trap_target;
            end else if (do_mret) begin
                redirect_pc <= mepc_q;
            end
        end
    end

endmodule

// File: tb/tb_csrfile_mtrap.sv
// Randomised scoreboard bench for csrfile_mtrap against an address-indexed
// behavioural model of the machine CSR state.
module tb_csrfile_mtrap;

    localparam int XLEN   = 64;
    localparam int HARTID = 5;
    localparam bit VEC    = 1'b1;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    typedef struct {
        logic        rst_n;
        logic [11:0] raddr;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        retire;
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic [63:0] exc_pc;
        logic [63:0] exc_tval;
        logic        mret;
        logic        int_ok;
        logic        msip;
        logic        mtip;
        logic        meip;
    } stim_t;

    typedef struct {
        logic [63:0] rdata;
        logic        rillegal;
        logic        int_take;
        logic        rv;
        logic [1:0]  priv;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [11:0]     raddr;
    logic [XLEN-1:0] rdata;
    logic            rillegal;
    logic            wen;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic            retire;
    logic            exc_valid;
    logic [4:0]      exc_code;
    logic [XLEN-1:0] exc_pc;
    logic [XLEN-1:0] exc_tval;
    logic            mret;
    logic            int_ok;
    logic            irq_msip;
    logic            irq_mtip;
    logic            irq_meip;
    logic            int_take;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      priv;

    csrfile_mtrap #(.XLEN(XLEN), .HARTID(HARTID), .VECTORED_EN(VEC)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rillegal(rillegal),
        .wen(wen), .waddr(waddr), .wdata(wdata), .retire(retire),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .int_ok(int_ok), .irq_msip(irq_msip), .irq_mtip(irq_mtip),
        .irq_meip(irq_meip), .int_take(int_take), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .priv(priv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] csr [logic [11:0]];
    logic [1:0]  m_priv;
    logic        m_rv;
    logic [63:0] redir_q [$];
    exp_t        exp_q [$];
    int          n_checks;
    int          n_fails;
    logic        r_msip, r_mtip, r_meip;

    function automatic void model_reset();
        if (m_rv === 1'b1) void'(redir_q.pop_back());
        m_rv   = 1'b0;
        m_priv = 2'd3;
        csr.delete();
        csr[A_MSTATUS]  = 64'h0;
        csr[A_MIE]      = 64'h0;
        csr[A_MTVEC]    = 64'h0;
        csr[A_MSCRATCH] = 64'h0;
        csr[A_MEPC]     = 64'h0;
        csr[A_MCAUSE]   = 64'h0;
        csr[A_MTVAL]    = 64'h0;
        csr[A_MIP]      = 64'h0;
        csr[A_MCYCLE]   = 64'h0;
        csr[A_MINSTRET] = 64'h0;
        csr[A_MHARTID]  = 64'(HARTID);
    endfunction

    function automatic logic model_int_take(input stim_t s, output int code);
        logic [63:0] pend;
        pend = csr[A_MIP] & csr[A_MIE];
        code = pend[11] ? 11 : (pend[3] ? 3 : 7);
        return s.int_ok && (m_priv < 2'd3 || csr[A_MSTATUS][3]) && (pend != 64'h0) && !s.exc_valid;
    endfunction

    function automatic void model_step(input stim_t s);
        int          code;
        logic        take;
        logic [63:0] st;
        logic [63:0] tgt;
        take = model_int_take(s, code);
        st   = csr[A_MSTATUS];
        csr[A_MCYCLE]   = csr[A_MCYCLE] + 64'd1;
        csr[A_MINSTRET] = csr[A_MINSTRET] + 64'(s.retire);
        m_rv = 1'b0;
        if (s.exc_valid || take) begin
            csr[A_MEPC]    = s.exc_pc;
            csr[A_MTVAL]   = take ? 64'h0 : s.exc_tval;
            csr[A_MCAUSE]  = take ? ((64'h1 << 63) + 64'(code)) : 64'(s.exc_code);
            csr[A_MSTATUS] = (st[3] ? 64'h80 : 64'h0) | (64'(m_priv) << 11);
            m_priv = 2'd3;
            tgt = csr[A_MTVEC] & ~64'h3;
            if (take && csr[A_MTVEC][0]) tgt = tgt + 64'(4 * code);
            redir_q.push_back(tgt);
            m_rv = 1'b1;
        end else if (s.mret) begin
            csr[A_MSTATUS] = (st[7] ? 64'h8 : 64'h0) | 64'h80;
            m_priv = st[12:11];
            redir_q.push_back(csr[A_MEPC]);
            m_rv = 1'b1;
        end else if (s.wen && m_priv == 2'd3) begin
            case (s.waddr)
                A_MSTATUS: csr[A_MSTATUS] = s.wdata & 64'h1888;
                A_MTVEC:   csr[A_MTVEC]   = s.wdata & (VEC ? ~64'h2 : ~64'h3);
                A_MEPC:    csr[A_MEPC]    = s.wdata & ~64'h3;
                A_MIE, A_MSCRATCH, A_MCAUSE, A_MTVAL, A_MCYCLE, A_MINSTRET:
                    csr[s.waddr] = s.wdata;
                default: ;
            endcase
        end
        csr[A_MIP] = (64'(s.meip) << 11) | (64'(s.mtip) << 7) | (64'(s.msip) << 3);
    endfunction

    function automatic stim_t idle(input logic [11:0] ra);
        stim_t s;
        s.rst_n = 1'b1; s.raddr = ra; s.wen = 1'b0; s.waddr = 12'h0; s.wdata = 64'h0;
        s.retire = 1'b0; s.exc_valid = 1'b0; s.exc_code = 5'h0; s.exc_pc = 64'h0;
        s.exc_tval = 64'h0; s.mret = 1'b0; s.int_ok = 1'b0;
        s.msip = 1'b0; s.mtip = 1'b0; s.meip = 1'b0;
        return s;
    endfunction

    function automatic stim_t wr(input logic [11:0] a, input logic [63:0] d, input logic [11:0] ra);
        stim_t s;
        s = idle(ra);
        s.wen = 1'b1; s.waddr = a; s.wdata = d;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        raddr = s.raddr; wen = s.wen; waddr = s.waddr; wdata = s.wdata;
        retire = s.retire; exc_valid = s.exc_valid; exc_code = s.exc_code;
        exc_pc = s.exc_pc; exc_tval = s.exc_tval; mret = s.mret; int_ok = s.int_ok;
        irq_msip = s.msip; irq_mtip = s.mtip; irq_meip = s.meip;
    endtask

    task automatic push_expect(input stim_t s);
        exp_t e;
        int   code;
        e.rdata    = csr.exists(s.raddr) ? csr[s.raddr] : 64'h0;
        e.rillegal = !csr.exists(s.raddr) || (m_priv != 2'd3);
        e.int_take = model_int_take(s, code);
        e.rv       = m_rv;
        e.priv     = m_priv;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input stim_t s);
        drive(s);
        reset = s.rst_n;
        if (!s.rst_n) model_reset();
        push_expect(s);
        if (s.rst_n) model_step(s);
        @(posedge clk);
        #1;
    endtask

    // Reset lands mid-cycle, after the trap event is already on the inputs.
    task automatic reset_mid_cycle(input stim_t s);
        drive(s);
        #1;
        reset = 1'b0;
        model_reset();
        push_expect(s);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        compare("rdata", rdata, e.rdata);
        compare("rillegal", 64'(rillegal), 64'(e.rillegal));
        compare("int_take", 64'(int_take), 64'(e.int_take));
        compare("redirect_valid", 64'(redirect_valid), 64'(e.rv));
        compare("priv", 64'(priv), 64'(e.priv));
        if (redirect_valid === 1'b1) begin
            if (redir_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL redirect_pc: unexpected redirect to %h at %0t", redirect_pc, $time);
            end else begin
                compare("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end else if (e.rv && redir_q.size() != 0) begin
            void'(redir_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) check_output(exp_q.pop_front());
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] pick_addr();
        logic [11:0] list [13];
        list = '{A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
                 A_MIP, A_MCYCLE, A_MINSTRET, A_MHARTID, 12'h7C0, 12'h301};
        if ($urandom_range(0, 9) == 0) return 12'($urandom);
        return list[$urandom_range(0, 12)];
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle(pick_addr());
        s.wen       = ($urandom_range(0, 2) == 0);
        s.waddr     = pick_addr();
        s.wdata     = {$urandom, $urandom};
        s.retire    = 1'($urandom_range(0, 1));
        s.exc_valid = ($urandom_range(0, 15) == 0);
        s.exc_code  = 5'($urandom);
        s.exc_pc    = {$urandom, $urandom};
        s.exc_tval  = {$urandom, $urandom};
        s.mret      = ($urandom_range(0, 11) == 0);
        s.int_ok    = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) r_msip = ~r_msip;
        if ($urandom_range(0, 7) == 0) r_mtip = ~r_mtip;
        if ($urandom_range(0, 7) == 0) r_meip = ~r_meip;
        s.msip = r_msip; s.mtip = r_mtip; s.meip = r_meip;
        return s;
    endfunction

    initial begin
        stim_t s;
        n_checks = 0;
        n_fails  = 0;
        m_rv     = 1'b0;
        r_msip   = 1'b0; r_mtip = 1'b0; r_meip = 1'b0;
        reset    = 1'b0;
        drive(idle(12'h0));
        model_reset();
        @(posedge clk);
        #1;

        s = idle(A_MHARTID); s.rst_n = 1'b0;
        apply_stimulus(s);
        apply_stimulus(s);
        apply_stimulus(idle(A_MHARTID));
        repeat (3) apply_stimulus(idle(A_MCYCLE));
        apply_stimulus(idle(12'h7C0));

        // Exception with a same-cycle mscratch write that must be dropped.
        apply_stimulus(wr(A_MTVEC, 64'h1000, A_MTVEC));
        apply_stimulus(wr(A_MSCRATCH, 64'h1234, A_MSCRATCH));
        apply_stimulus(wr(A_MSTATUS, 64'h8, A_MSTATUS));
        s = wr(A_MSCRATCH, 64'h55, A_MSCRATCH);
        s.exc_valid = 1'b1; s.exc_code = 5'd2; s.exc_pc = 64'h80; s.exc_tval = 64'hDEAD;
        apply_stimulus(s);
        apply_stimulus(idle(A_MEPC));
        apply_stimulus(idle(A_MCAUSE));
        apply_stimulus(idle(A_MTVAL));
        apply_stimulus(idle(A_MSTATUS));
        apply_stimulus(idle(A_MSCRATCH));

        // Vectored interrupt: MEI must win over MTI.
        apply_stimulus(wr(A_MTVEC, 64'h2001, A_MTVEC));
        apply_stimulus(wr(A_MSTATUS, 64'h8, A_MSTATUS));
        apply_stimulus(wr(A_MIE, 64'h888, A_MIE));
        s = idle(A_MIP); s.mtip = 1'b1; s.meip = 1'b1;
        apply_stimulus(s);
        s.int_ok = 1'b1; s.exc_pc = 64'h1F0;
        apply_stimulus(s);
        apply_stimulus(idle(A_MCAUSE));
        apply_stimulus(idle(A_MTVAL));
        apply_stimulus(idle(A_MSTATUS));

        // MRET to user mode, mepc write in the same cycle is dropped.
        apply_stimulus(wr(A_MSTATUS, 64'h80, A_MSTATUS));
        apply_stimulus(wr(A_MEPC, 64'h44, A_MEPC));
        s = wr(A_MEPC, 64'h999, A_MEPC); s.mret = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle(A_MSTATUS));
        apply_stimulus(idle(A_MEPC));
        s = idle(A_MSTATUS); s.exc_valid = 1'b1; s.exc_code = 5'd8; s.exc_pc = 64'h48;
        apply_stimulus(s);
        apply_stimulus(idle(A_MSTATUS));

        // minstret wrap.
        s = wr(A_MINSTRET, '1, A_MINSTRET); s.retire = 1'b1;
        apply_stimulus(s);
        s = idle(A_MINSTRET); s.retire = 1'b1;
        apply_stimulus(s);
        apply_stimulus(idle(A_MINSTRET));

        // Reset while a trap redirect is being captured.
        s = idle(A_MEPC); s.exc_valid = 1'b1; s.exc_code = 5'd5; s.exc_pc = 64'h300;
        reset_mid_cycle(s);
        s = idle(A_MTVEC); s.rst_n = 1'b0;
        apply_stimulus(s);
        s = idle(A_MSCRATCH); s.rst_n = 1'b0;
        apply_stimulus(s);
        apply_stimulus(idle(A_MCAUSE));
        apply_stimulus(idle(A_MSTATUS));

        for (int i = 0; i < 3000; i++) apply_stimulus(rand_stim());
        r_msip = 1'b0; r_mtip = 1'b0; r_meip = 1'b0;
        repeat (3) apply_stimulus(idle(A_MCYCLE));

        compare("redirect_drain", 64'(redir_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
